// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl
// Owns the fetch PC of the pipelined core and selects the next PC from
// PC+4, a taken conditional branch (branch & zero) or an unconditional jump.
// Every redirect is followed by a one-cycle registered IF/ID flush.
//
// Optional feature macro: PC_BRANCH_STATS_EN
//   When defined, adds saturating counters of accepted branches and of
//   accepted taken branches (branch_cnt_o / taken_cnt_o).
//   When undefined, those ports and their logic do not exist.

module pc_branch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic              zero_i,
    input  logic              jump_i,
    input  logic [31:0]       branch_target_i,
    input  logic [31:0]       jump_target_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc_plus4_o,
    output logic [1:0]        pc_src_o,
    output logic              flush_o
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  taken_cnt_o
`endif
);

    // Next-PC select encoding, visible on pc_src_o.
    localparam logic [1:0] SRC_SEQ    = 2'd0;
    localparam logic [1:0] SRC_BRANCH = 2'd1;
    localparam logic [1:0] SRC_JUMP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // A zero-width counter cannot hold any statistic; reject it at elaboration.
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pc_branch_ctrl: CNT_W must be at least 1");
    end

    // Instructions are word aligned: the low two address bits are dropped
    // whenever a redirect target is loaded into the PC.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        flush_q;
    logic        flush_d;
    logic [1:0]  pc_src_s;
    logic [31:0] pc_plus4_s;
    logic        taken_s;

    // Sequential address; wraps modulo 2^32 without any flag.
    assign pc_plus4_s = pc_q + 32'd4;
    assign taken_s    = branch_i & zero_i;

    // Next-state, next-PC and redirect-select decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flush_d  = 1'b0;
        pc_src_s = SRC_SEQ;
        case (state_q)
            ST_IDLE: begin
                // PC parks at the reset vector until fetching is started.
                pc_d = RESET_PC;
                if (start_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stall_i) begin
                    // Hazard stall: hold the PC and defer any redirect.
                    pc_d = pc_q;
                end else if (jump_i) begin
                    // Jump wins over a simultaneous taken branch.
                    pc_d     = word_align(jump_target_i);
                    pc_src_s = SRC_JUMP;
                    flush_d  = 1'b1;
                    state_d  = ST_FLUSH;
                end else if (taken_s) begin
                    pc_d     = word_align(branch_target_i);
                    pc_src_s = SRC_BRANCH;
                    flush_d  = 1'b1;
                    state_d  = ST_FLUSH;
                end else begin
                    pc_d = pc_plus4_s;
                end
            end
            ST_FLUSH: begin
                // ID holds the squashed wrong-path instruction, so its
                // branch/jump decode is ignored here.
                if (stall_i) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_plus4_s;
                end
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = RESET_PC;
            end
        endcase
    end

    // Control FSM: state, PC and the registered flush pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_s;
    assign pc_src_o   = pc_src_s;
    assign flush_o    = flush_q;

`ifdef PC_BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] branch_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] taken_cnt_d;
    logic             branch_acc_s;
    logic             taken_acc_s;

    // A branch counts only when it is actually evaluated: in RUN without stall.
    // A taken branch shadowed by a jump is not counted as taken.
    always_comb begin
        branch_acc_s = 1'b0;
        taken_acc_s  = 1'b0;
        if ((state_q == ST_RUN) && !stall_i && branch_i) begin
            branch_acc_s = 1'b1;
            taken_acc_s  = zero_i & ~jump_i;
        end else begin
            branch_acc_s = 1'b0;
            taken_acc_s  = 1'b0;
        end
    end

    // Saturating increment of both statistics counters.
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        if (branch_acc_s && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            branch_cnt_d = branch_cnt_q;
        end
        if (taken_acc_s && (taken_cnt_q != CNT_MAX)) begin
            taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            taken_cnt_d = taken_cnt_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt_q <= {CNT_W{1'b0}};
            taken_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign branch_cnt_o = branch_cnt_q;
    assign taken_cnt_o  = taken_cnt_q;
`endif

endmodule
